// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: shared constants for the two-entry skid pipeline register.
// The state encoding equals the entry count, so the state register is the occupancy.
package pipe_skid_reg_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ST_BUSY  = 2'd1;
    localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_reg_flopenr.sv
// flopenr: WIDTH-bit register with load enable and async active-high reset to 0.
// Ports: clk, reset, en (load), d (next value), q (held value).
module flopenr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry elastic register (main + skid) with valid/ready on both sides.
// Ports: clk, reset (async), flush (sync); in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream; occupancy = entries held (0..2).
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_en;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_skid_q;

    // Handshake outputs come from the state register only.
    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = (r_state != ST_FULL);
    assign occupancy = r_state;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Head refills from the skid entry when draining FULL, otherwise from upstream.
    assign w_main_d = (r_state == ST_FULL) ? w_skid_q : in_data;

    always_comb begin
        w_state_nxt = r_state;
        w_main_en   = 1'b0;
        w_skid_en   = 1'b0;
        unique case (1'b1)
            (r_state == ST_EMPTY): begin
                if (w_in_fire) begin
                    w_main_en   = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            (r_state == ST_BUSY): begin
                if (w_in_fire && w_out_fire) begin
                    w_main_en = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_en   = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            (r_state == ST_FULL): begin
                if (w_out_fire) begin
                    w_main_en   = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // Flush empties the buffer; an out_fire on the same edge is still
        // consumed downstream, but no entry is loaded.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_en   = 1'b0;
            w_skid_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    flopenr #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (w_main_en),
        .d     (w_main_d),
        .q     (out_data)
    );

    flopenr #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (w_skid_en),
        .d     (in_data),
        .q     (w_skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and scoreboard tests for pipe_skid_reg.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_pipe_skid_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int n_pass;
    int n_total;

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = 32'h0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_ov got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_ir got=%b exp=1", in_ready); else n_pass++;
        n_total++; if (occupancy !== 2'd0) $display("FAIL rst_occ got=%0d exp=0", occupancy); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL rst_data got=%h exp=0", out_data); else n_pass++;
        // Fill to FULL, then assert reset mid-cycle.
        in_valid = 1'b1; in_data = 32'hDEAD0001;
        tick();
        in_data = 32'hDEAD0002;
        tick();
        in_valid = 1'b0;
        n_total++; if (occupancy !== 2'd2) $display("FAIL rst_pre_full got=%0d exp=2", occupancy); else n_pass++;
        #3;
        reset = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL arst_ov got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL arst_ir got=%b exp=1", in_ready); else n_pass++;
        n_total++; if (occupancy !== 2'd0) $display("FAIL arst_occ got=%0d exp=0", occupancy); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL arst_data got=%h exp=0", out_data); else n_pass++;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream;
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vals[i];
            n_total++; if (in_ready !== 1'b1) $display("FAIL stream_ir%0d got=%b exp=1", i, in_ready); else n_pass++;
            tick();
            n_total++; if (out_data !== vals[i]) $display("FAIL stream_d%0d got=%h exp=%h", i, out_data, vals[i]); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL stream_ov%0d got=%b exp=1", i, out_valid); else n_pass++;
            n_total++; if (occupancy !== 2'd1) $display("FAIL stream_occ%0d got=%0d exp=1", i, occupancy); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_total++; if (occupancy !== 2'd0) $display("FAIL stream_drain got=%0d exp=0", occupancy); else n_pass++;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA0;
        tick();
        in_data = 32'hA1;
        tick();
        n_total++; if (occupancy !== 2'd2) $display("FAIL bp_occ got=%0d exp=2", occupancy); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ir got=%b exp=0", in_ready); else n_pass++;
        n_total++; if (out_data !== 32'hA0) $display("FAIL bp_head got=%h exp=A0", out_data); else n_pass++;
        in_data = 32'hA2;
        tick();
        n_total++; if (occupancy !== 2'd2) $display("FAIL bp_hold_occ got=%0d exp=2", occupancy); else n_pass++;
        n_total++; if (out_data !== 32'hA0) $display("FAIL bp_hold_head got=%h exp=A0", out_data); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++; if (out_data !== 32'hA1) $display("FAIL bp_second got=%h exp=A1", out_data); else n_pass++;
        n_total++; if (occupancy !== 2'd1) $display("FAIL bp_occ1 got=%0d exp=1", occupancy); else n_pass++;
        tick();
        n_total++; if (out_data !== 32'hA2) $display("FAIL bp_third got=%h exp=A2", out_data); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL bp_third_ov got=%b exp=1", out_valid); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_total++; if (occupancy !== 2'd0) $display("FAIL bp_drain got=%0d exp=0", occupancy); else n_pass++;
    endtask

    task automatic test_simul;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        tick();
        n_total++; if (out_data !== 32'h5) $display("FAIL sim_main got=%h exp=5", out_data); else n_pass++;
        in_data   = 32'h6;
        out_ready = 1'b1;
        tick();
        n_total++; if (out_data !== 32'h6) $display("FAIL sim_data got=%h exp=6", out_data); else n_pass++;
        n_total++; if (occupancy !== 2'd1) $display("FAIL sim_occ got=%0d exp=1", occupancy); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_total++; if (occupancy !== 2'd0) $display("FAIL sim_drain got=%0d exp=0", occupancy); else n_pass++;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        n_total++; if (occupancy !== 2'd2) $display("FAIL fl_full got=%0d exp=2", occupancy); else n_pass++;
        in_data   = 32'hFF;
        out_ready = 1'b1;
        flush     = 1'b1;
        n_total++; if (out_data !== 32'h1) $display("FAIL fl_head got=%h exp=1", out_data); else n_pass++;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_total++; if (occupancy !== 2'd0) $display("FAIL fl_occ got=%0d exp=0", occupancy); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL fl_ov got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL fl_ir got=%b exp=1", in_ready); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL fl_after_ov got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] q[$];
        logic [31:0] next_val;
        logic [31:0] held;
        logic        hold;
        next_val = 32'h1000;
        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = next_val;
            if (out_valid && out_ready) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_extra cyc=%0d got=%h exp=none", i, out_data);
                end else begin
                    if (out_data !== q[0]) $display("FAIL rnd_order cyc=%0d got=%h exp=%h", i, out_data, q[0]);
                    else n_pass++;
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(next_val);
                next_val = next_val + 32'd1;
            end
            hold = out_valid && !out_ready;
            held = out_data;
            tick();
            if (hold) begin
                n_total++; if (out_valid !== 1'b1 || out_data !== held) $display("FAIL rnd_stable cyc=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, held); else n_pass++;
            end
            n_total++; if (occupancy !== 2'(q.size())) $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", i, occupancy, q.size()); else n_pass++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid && q.size() != 0) begin
                n_total++; if (out_data !== q[0]) $display("FAIL rnd_drain got=%h exp=%h", out_data, q[0]); else n_pass++;
                void'(q.pop_front());
            end
            tick();
        end
        n_total++; if (q.size() != 0 || occupancy !== 2'd0) $display("FAIL rnd_end got=%0d/%0d exp=0/0", q.size(), occupancy); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_simul();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
